controlador_load_store: RTL and testbench

//  Initiator side of the data-memory interface: accepts one load/store request at a time

---
 rtl/pacote_mips_pkg.sv | 38 +++
 rtl/controlador_load_store_if.sv | 30 +++
 rtl/alinhador_bytes.sv | 40 ++++
 rtl/controlador_load_store.sv | 160 ++++++++++++++++
 tb/tb_controlador_load_store.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/pacote_mips_pkg.sv
// Shared definitions for the load/store controller: op encodings, FSM states, decode helpers.
package pacote_mips_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_MERGE,
    S_WR,
    S_DONE
  } state_e;

  function automatic logic is_load(op_e op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  // Word accesses need both low bits clear, halfword accesses only bit 0.
  function automatic logic is_misaligned(op_e op, logic [1:0] off);
    case (op)
      OP_LW, OP_SW:         return off != 2'b00;
      OP_LH, OP_LHU, OP_SH: return off[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/controlador_load_store_if.sv
// Request/response and data-memory bus of the load/store controller.
interface controlador_load_store_if #(
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_endereco;
  logic [31:0]       mem_dado;
  logic              mem_memread;
  logic              mem_memwrite;
  logic [31:0]       mem_readdata;
  logic              excecao;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, mem_readdata,
    output req_ready, resp_valid, resp_rdata, mem_endereco, mem_dado,
           mem_memread, mem_memwrite, excecao
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, mem_readdata,
    input  req_ready, resp_valid, resp_rdata, mem_endereco, mem_dado,
           mem_memread, mem_memwrite, excecao
  );
endinterface

// File: rtl/alinhador_bytes.sv
// Little-endian lane logic: load extract with sign/zero extension and sub-word store merge.
module alinhador_bytes
  import pacote_mips_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  off,
  input  logic [31:0] rd_word,
  input  logic [31:0] st_base,
  input  logic [31:0] st_data,
  output logic [31:0] ld_result,
  output logic [31:0] st_word
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = 8'(rd_word >> {off, 3'b000});
  assign lane_h = 16'(rd_word >> {off[1], 4'b0000});

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    ld_result = rd_word;
    case (op)
      OP_LH:   ld_result = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  ld_result = {16'h0000, lane_h};
      OP_LB:   ld_result = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  ld_result = {24'h000000, lane_b};
      default: ld_result = rd_word;
    endcase
  end

  always_comb begin
    st_word = st_base;
    case (op)
      OP_SB:   st_word[{off, 3'b000} +: 8]     = st_data[7:0];
      OP_SH:   st_word[{off[1], 4'b0000} +: 16] = st_data[15:0];
      OP_SW:   st_word = st_data;
      default: st_word = st_base;
    endcase
  end
endmodule

// File: rtl/controlador_load_store.sv
// Load/store initiator: word-addressed memory strobes, sub-word loads and read-modify-write stores.
// Optional MISALIGN_TRAP_EN: misaligned word/half accesses complete at once with excecao set.
module controlador_load_store
  import pacote_mips_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int MEM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  controlador_load_store_if.master  bus
);
  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] endereco_q, endereco_d;
  logic [31:0]       dado_q, dado_d;
  logic              memread_q, memread_d;
  logic              memwrite_q, memwrite_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              excecao_q, excecao_d;

  op_e         op_in;
  logic        misalign;
  logic [31:0] ld_result;
  logic [31:0] st_word;
  logic        unused_addr_bits;

  assign op_in            = op_e'(bus.req_op);
  assign unused_addr_bits = ^bus.req_addr[31:ADDR_W+2];

`ifdef MISALIGN_TRAP_EN
  assign misalign = is_misaligned(op_in, bus.req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  alinhador_bytes u_alinhador (
    .op        (op_q),
    .off       (off_q),
    .rd_word   (bus.mem_readdata),
    .st_base   (rdata_q),
    .st_data   (wdata_q),
    .ld_result (ld_result),
    .st_word   (st_word)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    endereco_d   = endereco_q;
    dado_d       = dado_q;
    resp_rdata_d = resp_rdata_q;
    memread_d    = 1'b0;
    memwrite_d   = 1'b0;
    resp_valid_d = 1'b0;
    excecao_d    = 1'b0;
    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        op_d       = op_in;
        off_d      = bus.req_addr[1:0];
        wdata_d    = bus.req_wdata;
        endereco_d = bus.req_addr[ADDR_W+1:2];
        if (misalign) begin
          resp_valid_d = 1'b1;
          excecao_d    = 1'b1;
          state_d      = S_DONE;
        end else if (op_in == OP_SW) begin
          dado_d     = bus.req_wdata;
          memwrite_d = 1'b1;
          state_d    = S_WR;
        end else begin
          memread_d = 1'b1;
          state_d   = S_RD;
        end
      end
      S_RD: begin
        cnt_d   = 8'(MEM_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          rdata_d = bus.mem_readdata;
          if (is_load(op_q)) begin
            resp_rdata_d = ld_result;
            resp_valid_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            state_d = S_MERGE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_MERGE: begin
        dado_d     = st_word;
        memwrite_d = 1'b1;
        state_d    = S_WR;
      end
      S_WR: begin
        resp_valid_d = 1'b1;
        state_d      = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it is tested inside the clocked block and all state
  // updates use non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= OP_LW;
      off_q        <= 2'b00;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
      endereco_q   <= '0;
      dado_q       <= '0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      excecao_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
      endereco_q   <= endereco_d;
      dado_q       <= dado_d;
      memread_q    <= memread_d;
      memwrite_q   <= memwrite_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      excecao_q    <= excecao_d;
    end
  end

  // Gating with reset suppresses a strobe already registered when an abort arrives.
  assign bus.req_ready    = (state_q == S_IDLE) && !reset;
  assign bus.mem_memread  = memread_q  && !reset;
  assign bus.mem_memwrite = memwrite_q && !reset;
  assign bus.resp_valid   = resp_valid_q && !reset;
  assign bus.excecao      = excecao_q  && !reset;
  assign bus.mem_endereco = endereco_q;
  assign bus.mem_dado     = dado_q;
  assign bus.resp_rdata   = resp_rdata_q;
endmodule

// File: tb/tb_controlador_load_store.sv
// Directed bench for controlador_load_store with a one-cycle-latency word memory model.
module tb_controlador_load_store;
  import pacote_mips_pkg::*;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  controlador_load_store_if #(.ADDR_W(5)) bus ();

  controlador_load_store #(.ADDR_W(5), .MEM_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read (data valid the cycle after memread), plus a poke port.
  logic [31:0] mem [32];
  logic        poke_en;
  logic [4:0]  poke_idx;
  logic [31:0] poke_val;
  logic [31:0] rd_q;

  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    if (bus.mem_memwrite) mem[bus.mem_endereco] <= bus.mem_dado;
    if (bus.mem_memread) rd_q <= mem[bus.mem_endereco];
  end
  assign bus.mem_readdata = rd_q;

  // Strobe monitor sampled on the falling edge.
  int         n_rd = 0, n_wr = 0, n_both = 0;
  logic [4:0] last_rd_idx, last_wr_idx;
  logic [31:0] last_wr_data;

  always @(negedge clk) begin
    if (bus.mem_memread) begin
      n_rd++;
      last_rd_idx = bus.mem_endereco;
    end
    if (bus.mem_memwrite) begin
      n_wr++;
      last_wr_idx  = bus.mem_endereco;
      last_wr_data = bus.mem_dado;
    end
    if (bus.mem_memread && bus.mem_memwrite) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [4:0] idx, input logic [31:0] val);
    poke_idx = idx;
    poke_val = val;
    poke_en  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Issue one request from a falling edge; lat counts cycles after the accept edge.
  task automatic do_req(input string tag, input op_e op, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat,
                        output logic [31:0] rdata, output logic exc);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat   = 0;
    rdata = '0;
    exc   = 1'b0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      if (bus.resp_valid) begin
        lat   = k;
        rdata = bus.resp_rdata;
        exc   = bus.excecao;
      end else begin
        @(negedge clk);
      end
    end
    check({tag, "_resp_seen"}, 32'(lat != 0), 32'd1);
  endtask

  int          lat;
  logic [31:0] rdata;
  logic        exc;
  int          rd0, wr0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected finish");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    poke_en       = 1'b0;
    poke_idx      = '0;
    poke_val      = '0;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'b000;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready",      32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_memread",    32'(bus.mem_memread), 32'd0);
    check("rst_memwrite",   32'(bus.mem_memwrite), 32'd0);
    check("rst_excecao",    32'(bus.excecao), 32'd0);
    check("rst_endereco",   32'(bus.mem_endereco), 32'd0);
    check("rst_dado",       bus.mem_dado, 32'd0);
    check("rst_rdata",      bus.resp_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);

    // LW word 3
    poke(5'd3, 32'hDEADBEEF);
    rd0 = n_rd; wr0 = n_wr;
    do_req("lw", OP_LW, 32'h0000_000C, 32'h0, lat, rdata, exc);
    check("lw_lat",    32'(lat), 32'd3);
    check("lw_rdata",  rdata, 32'hDEADBEEF);
    check("lw_nread",  32'(n_rd - rd0), 32'd1);
    check("lw_rd_idx", 32'(last_rd_idx), 32'd3);
    check("lw_nwrite", 32'(n_wr - wr0), 32'd0);
    check("lw_exc",    32'(exc), 32'd0);
    @(negedge clk);

    // Byte loads from lane 1
    poke(5'd3, 32'h0000_80FF);
    do_req("lb", OP_LB, 32'h0000_000D, 32'h0, lat, rdata, exc);
    check("lb_lat",   32'(lat), 32'd3);
    check("lb_rdata", rdata, 32'hFFFF_FF80);
    @(negedge clk);
    do_req("lbu", OP_LBU, 32'h0000_000D, 32'h0, lat, rdata, exc);
    check("lbu_rdata", rdata, 32'h0000_0080);
    @(negedge clk);

    // Halfword loads from upper half
    poke(5'd3, 32'h8000_1234);
    do_req("lh", OP_LH, 32'h0000_000E, 32'h0, lat, rdata, exc);
    check("lh_rdata", rdata, 32'hFFFF_8000);
    @(negedge clk);
    do_req("lhu", OP_LHU, 32'h0000_000E, 32'h0, lat, rdata, exc);
    check("lhu_rdata", rdata, 32'h0000_8000);
    @(negedge clk);

    // SB read-modify-write into lane 2; resp_rdata holds the last load value
    poke(5'd3, 32'h1122_3344);
    rd0 = n_rd; wr0 = n_wr;
    do_req("sb", OP_SB, 32'h0000_000E, 32'h0000_00AB, lat, rdata, exc);
    check("sb_nread",   32'(n_rd - rd0), 32'd1);
    check("sb_nwrite",  32'(n_wr - wr0), 32'd1);
    check("sb_wr_idx",  32'(last_wr_idx), 32'd3);
    check("sb_wr_data", last_wr_data, 32'h11AB_3344);
    check("sb_rdata_held", rdata, 32'h0000_8000);
    @(negedge clk);
    check("sb_mem", mem[3], 32'h11AB_3344);

    // SH into upper half of word 1
    poke(5'd1, 32'hAABB_CCDD);
    do_req("sh", OP_SH, 32'h0000_0006, 32'h1234_BEEF, lat, rdata, exc);
    check("sh_wr_idx",  32'(last_wr_idx), 32'd1);
    check("sh_wr_data", last_wr_data, 32'hBEEF_CCDD);
    @(negedge clk);

    // SW with wrap-around address
    rd0 = n_rd; wr0 = n_wr;
    do_req("sw", OP_SW, 32'h0000_0080, 32'h0000_0005, lat, rdata, exc);
    check("sw_lat",     32'(lat), 32'd2);
    check("sw_nread",   32'(n_rd - rd0), 32'd0);
    check("sw_nwrite",  32'(n_wr - wr0), 32'd1);
    check("sw_wr_idx",  32'(last_wr_idx), 32'd0);
    check("sw_wr_data", last_wr_data, 32'd5);
    @(negedge clk);

    // Misaligned LW
    rd0 = n_rd; wr0 = n_wr;
    do_req("mis", OP_LW, 32'h0000_0002, 32'h0, lat, rdata, exc);
`ifdef MISALIGN_TRAP_EN
    check("mis_lat",    32'(lat), 32'd1);
    check("mis_exc",    32'(exc), 32'd1);
    check("mis_nread",  32'(n_rd - rd0), 32'd0);
    check("mis_rdata",  rdata, 32'h0000_8000);
`else
    check("mis_lat",    32'(lat), 32'd3);
    check("mis_exc",    32'(exc), 32'd0);
    check("mis_nread",  32'(n_rd - rd0), 32'd1);
    check("mis_rd_idx", 32'(last_rd_idx), 32'd0);
    check("mis_rdata",  rdata, 32'd5);
`endif
    check("mis_nwrite", 32'(n_wr - wr0), 32'd0);
    @(negedge clk);

    // Reset during WAIT of an SH: the write must never happen
    poke(5'd2, 32'h5555_5555);
    wr0 = n_wr;
    bus.req_valid = 1'b1;
    bus.req_op    = OP_SH;
    bus.req_addr  = 32'h0000_0008;
    bus.req_wdata = 32'h0000_9999;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 8; i++) @(negedge clk);
    check("abort_nwrite", 32'(n_wr - wr0), 32'd0);
    check("abort_mem",    mem[2], 32'h5555_5555);

    check("no_rd_wr_overlap", 32'(n_both), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
